// File: rtl/axil_fifo_wr_pkg.sv
// axil_fifo_wr_pkg: register map, response codes and AXI handshake states shared by the FIFO write slave
package axil_fifo_wr_pkg;
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_WCNT   = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int ST_EMPTY  = 16;
    localparam int ST_FULL   = 17;
    localparam int ST_OVF    = 18;
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;
endpackage

// File: rtl/axil_fifo_wr_slave_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO with flush; clr overrides any same-cycle push or pop
module sync_fifo_fwft #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    logic [WIDTH-1:0]      r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_push, w_pop;
    assign empty  = r_level == '0;
    assign full   = r_level == FULL_LVL;
    assign level  = r_level;
    assign dout   = empty ? '0 : r_mem[r_rptr];
    assign w_push = wr_en && !full && !clr;
    assign w_pop  = rd_en && !empty && !clr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= r_wptr + DEPTH_LOG2'(w_push);
            r_rptr  <= r_rptr + DEPTH_LOG2'(w_pop);
            r_level <= r_level + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
        end
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wptr] <= din;
endmodule

// File: rtl/axil_fifo_wr_slave.sv
// axil_fifo_wr_slave: AXI4-Lite register slave that pushes DATA writes into a FWFT FIFO drained by user logic
module axil_fifo_wr_slave
    import axil_fifo_wr_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH_LOG2    = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            fifo_rd_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   fifo_dout,
    output logic                            fifo_empty,
    output logic [FIFO_DEPTH_LOG2:0]        fifo_level
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    wr_state_t              r_wstate, w_wstate_nxt;
    rd_state_t              r_rstate, w_rstate_nxt;
    logic                   r_en, r_ovf;
    logic [DW-1:0]          r_wcnt, r_last, r_rdata;
    logic [1:0]             r_bresp;
    logic [1:0]             w_wsel, w_rsel;
    logic                   w_wr, w_data_wr, w_ctrl_wr, w_clr, w_push, w_full, w_empty;
    logic [FIFO_DEPTH_LOG2:0] w_level;
    logic [DW-1:0]          w_wcnt_wr, w_status, w_rd_mux;
    logic                   w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign w_wsel    = S_AXI_AWADDR[3:2];
    assign w_rsel    = S_AXI_ARADDR[3:2];
    assign w_wr      = r_wstate == W_ACK;
    assign w_data_wr = w_wr && w_wsel == ADDR_DATA;
    assign w_ctrl_wr = w_wr && w_wsel == ADDR_CTRL && S_AXI_WSTRB[0];
    assign w_clr     = w_ctrl_wr && S_AXI_WDATA[CTRL_CLR];
    assign w_push    = w_data_wr && r_en && !w_full;
    assign S_AXI_AWREADY = w_wr;
    assign S_AXI_WREADY  = w_wr;
    assign S_AXI_BVALID  = r_wstate == W_RESP;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_rstate == R_ACK;
    assign S_AXI_RVALID  = r_rstate == R_DATA;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign fifo_empty    = w_empty;
    assign fifo_level    = w_level;
    always_comb begin
        w_wstate_nxt = (r_wstate == W_IDLE && S_AXI_AWVALID && S_AXI_WVALID) ? W_ACK :
                       (r_wstate == W_ACK) ? W_RESP :
                       (r_wstate == W_RESP && S_AXI_BREADY) ? W_IDLE : r_wstate;
        w_rstate_nxt = (r_rstate == R_IDLE && S_AXI_ARVALID) ? R_ACK :
                       (r_rstate == R_ACK) ? R_DATA :
                       (r_rstate == R_DATA && S_AXI_RREADY) ? R_IDLE : r_rstate;
    end
    always_comb begin
        w_wcnt_wr = r_wcnt;
        for (int i = 0; i < DW/8; i++)
            w_wcnt_wr[8*i +: 8] = S_AXI_WSTRB[i] ? S_AXI_WDATA[8*i +: 8] : r_wcnt[8*i +: 8];
        w_status = '0;
        w_status[15:0] = 16'(w_level);
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL] = w_full;
        w_status[ST_OVF] = r_ovf;
        w_rd_mux = (w_rsel == ADDR_CTRL) ? DW'(r_en) :
                   (w_rsel == ADDR_DATA) ? r_last :
                   (w_rsel == ADDR_STATUS) ? w_status : r_wcnt;
    end
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_bresp  <= RESP_OKAY;
            r_en     <= 1'b0;
            r_ovf    <= 1'b0;
            r_wcnt   <= '0;
            r_last   <= '0;
            r_rdata  <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            if (w_wr) r_bresp <= (w_data_wr && !w_push) ? RESP_SLVERR : RESP_OKAY;
            if (w_ctrl_wr) r_en <= S_AXI_WDATA[CTRL_EN];
            if (w_clr) r_ovf <= 1'b0;
            else if (w_data_wr && r_en && w_full) r_ovf <= 1'b1;
            if (w_wr && w_wsel == ADDR_WCNT) r_wcnt <= w_wcnt_wr;
            else if (w_push) r_wcnt <= r_wcnt + 1'b1;
            if (w_push) r_last <= S_AXI_WDATA;
            if (r_rstate == R_ACK) r_rdata <= w_rd_mux;
        end
    sync_fifo_fwft #(.WIDTH(DW), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .clr   (w_clr),
        .wr_en (w_push),
        .din   (S_AXI_WDATA),
        .rd_en (fifo_rd_en),
        .dout  (fifo_dout),
        .empty (w_empty),
        .full  (w_full),
        .level (w_level)
    );
endmodule
